// File: rtl/cacheline_mem_arbiter_if.sv
// Bundle of the cache-side and memory-side buses around cacheline_mem_arbiter.
// master: the arbiter's view. It receives cache requests and memory beats, and
//         drives cache responses and the burst memory port.
// slave : the surrounding world's view, meaning the caches plus the memory.
// Ports : i_* icache fill, d_* dcache fill/writeback, mem_* burst memory port.
interface cacheline_mem_arbiter_if #(
  parameter int BEAT_W = 64,
  parameter int LINE_W = 256
);
  // Instruction cache side.
  logic              i_read;
  logic [31:0]       i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  // Data cache side.
  logic              d_read;
  logic              d_write;
  logic [31:0]       d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  // Burst memory port.
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_addr;
  logic [BEAT_W-1:0] mem_wdata;
  logic [BEAT_W-1:0] mem_rdata;
  logic              mem_resp;

  modport master (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cacheline_mem_arbiter.sv
// Purpose : arbitrates icache/dcache line fills and writebacks onto one burst memory port.
// Latency : grant 1 cycle after the request; then BURST_LEN accepted beats; resp pulses in DONE.
// Backpr. : mem_resp low stalls the burst in place. Losing requests wait for the next IDLE.
// Ports   : clk, reset_n (async, active low), bus (cacheline_mem_arbiter_if.master).
// Option  : `define ARB_ROUND_ROBIN_EN alternates between the caches when both request.
//           Otherwise the fixed order is d_write > d_read > i_read.
// LINE_W must equal BURST_LEN*BEAT_W. The mem_* signals drive the top-level mp4 memory port.
module cacheline_mem_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int BEAT_W    = 64,
  parameter int LINE_W    = 256
) (
  input  logic                   clk,
  input  logic                   reset_n,
  cacheline_mem_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(BURST_LEN);
  localparam int OFF_W = $clog2(LINE_W / 8);

  typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        addr_q;
  logic [LINE_W-1:0]  wline_q;
  logic [LINE_W-1:0]  rbuf_q;
  logic [LINE_W-1:0]  i_rdata_q;
  logic [LINE_W-1:0]  d_rdata_q;
  logic               owner_i_q;   // 1 while the icache owns the current burst

  logic               in_burst;
  logic               burst_rd;
  logic               last_beat;
  logic               grant;
  logic [31:0]        gnt_addr;
  logic [LINE_W-1:0]  rline_nxt;

`ifdef ARB_ROUND_ROBIN_EN
  logic               last_grant_q; // 0 = icache was granted last, 1 = dcache
  logic               d_req;
  assign d_req = bus.d_read | bus.d_write;
`endif

  assign burst_rd  = (state_q == I_RD) || (state_q == D_RD);
  assign in_burst  = burst_rd || (state_q == D_WR);
  assign last_beat = (cnt_q == CNT_W'(BURST_LEN - 1));
  assign grant     = (state_q == IDLE) && (state_d != IDLE);
  assign gnt_addr  = (state_d == I_RD) ? bus.i_addr : bus.d_addr;

  // Next-state logic. Arbitration happens only in IDLE, so a client that drops
  // its request during DONE is never granted twice.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
        if (d_req && (!bus.i_read || !last_grant_q)) begin
          state_d = bus.d_write ? D_WR : D_RD;
        end else if (bus.i_read) begin
          state_d = I_RD;
        end
`else
        if (bus.d_write) begin
          state_d = D_WR;
        end else if (bus.d_read) begin
          state_d = D_RD;
        end else if (bus.i_read) begin
          state_d = I_RD;
        end
`endif
      end
      I_RD, D_RD, D_WR: begin
        if (bus.mem_resp && last_beat) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read beats are staged in rbuf_q. The client's line register is only
  // overwritten on the last beat. That keeps the previous line stable until the
  // new one is complete.
  always_comb begin
    rline_nxt = rbuf_q;
    rline_nxt[cnt_q*BEAT_W +: BEAT_W] = bus.mem_rdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wline_q   <= '0;
      rbuf_q    <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      owner_i_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (grant) begin
        cnt_q     <= '0;
        owner_i_q <= (state_d == I_RD);
        addr_q    <= {gnt_addr[31:OFF_W], {OFF_W{1'b0}}};
        if (state_d == D_WR) begin
          wline_q <= bus.d_wdata;
        end
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_q <= (state_d != I_RD);
`endif
      end else if (in_burst && bus.mem_resp) begin
        cnt_q <= cnt_q + 1'b1;
        if (burst_rd) begin
          rbuf_q <= rline_nxt;
          if (last_beat) begin
            if (owner_i_q) begin
              i_rdata_q <= rline_nxt;
            end else begin
              d_rdata_q <= rline_nxt;
            end
          end
        end
      end
    end
  end

  // All strobes decode straight from the state register. Because the state
  // resets asynchronously, they drop as soon as reset_n asserts.
  assign bus.mem_read  = burst_rd;
  assign bus.mem_write = (state_q == D_WR);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wline_q[cnt_q*BEAT_W +: BEAT_W];
  assign bus.i_resp    = (state_q == DONE) && owner_i_q;
  assign bus.d_resp    = (state_q == DONE) && !owner_i_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Self-checking bench for cacheline_mem_arbiter. Expected transactions are queued
// when requests are driven and are popped when a cache response pulses.
// A behavioural memory answers bursts, optionally stalling every other cycle.
module tb_cacheline_mem_arbiter;
  localparam int BEAT_W = 64;
  localparam int LINE_W = 256;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  cacheline_mem_arbiter_if #(.BEAT_W(BEAT_W), .LINE_W(LINE_W)) bus();

  cacheline_mem_arbiter #(.BURST_LEN(4), .BEAT_W(BEAT_W), .LINE_W(LINE_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          is_i;
    bit          is_wr;
    logic [31:0] addr;
    logic [255:0] line;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    bit          is_i;
    bit          is_wr;
    logic [31:0] addr;
    logic [255:0] line;   // write data, or the data memory returns for reads
    bit          stall;
    logic [31:0] exp_addr;
    int          exp_cyc;
  } vec_t;
  vec_t vt[5];

  // Memory model and monitor state.
  logic [255:0] mem_line = '0;
  logic [255:0] wcap     = '0;
  logic [31:0]  burst_addr = '0;
  bit  stall_mode = 0, force_resp = 0, in_burst = 0, burst_wr = 0;
  int  mem_beat = 0, phase = 0, act_cyc = 0, last_cyc = 0, idle_cyc = 0, last_gap = 0;
  int  bursts = 0, i_resp_n = 0, d_resp_n = 0;
  bit  last_d = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      bus.mem_resp  = 1'b0;
      bus.mem_rdata = '0;
      mem_beat = 0;
      phase    = 0;
      in_burst = 0;
    end else begin
      if (bus.mem_read || bus.mem_write) begin
        if (!in_burst) begin
          in_burst   = 1;
          bursts++;
          last_gap   = idle_cyc;
          act_cyc    = 0;
          burst_addr = bus.mem_addr;
          burst_wr   = bus.mem_write;
          mem_beat   = 0;
          phase      = 0;
        end
        act_cyc++;
        if (stall_mode && phase == 0) begin
          bus.mem_resp  = 1'b0;
          bus.mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
          phase = 1;
        end else begin
          bus.mem_resp  = 1'b1;
          bus.mem_rdata = mem_line[(mem_beat % 4)*64 +: 64];
          wcap[(mem_beat % 4)*64 +: 64] = bus.mem_wdata;
          mem_beat++;
          phase = 0;
        end
      end else begin
        if (in_burst) begin
          in_burst = 0;
          last_cyc = act_cyc;
          idle_cyc = 0;
        end
        idle_cyc++;
        bus.mem_resp  = force_resp;
        bus.mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      end
      if (bus.i_resp || bus.d_resp) begin
        if (bus.i_resp) i_resp_n++;
        if (bus.d_resp) d_resp_n++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_resp actual=i%0d_d%0d required=none", bus.i_resp, bus.d_resp);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_client_is_i", {255'd0, bus.i_resp}, {255'd0, mon_e.is_i});
          chk("sb_burst_addr", {224'd0, burst_addr}, {224'd0, mon_e.addr});
          chk("sb_burst_kind", {255'd0, burst_wr}, {255'd0, mon_e.is_wr});
          chk("sb_line", mon_e.is_wr ? wcap : (mon_e.is_i ? bus.i_rdata : bus.d_rdata), mon_e.line);
        end
      end
    end
  end

  task automatic wait_resp(input bit is_i, input int budget, input bit scramble);
    bit seen = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (scramble && c == 1) begin
        bus.i_addr  = ~bus.i_addr;
        bus.d_addr  = ~bus.d_addr;
        bus.d_wdata = ~bus.d_wdata;
      end
      if (is_i ? bus.i_resp : bus.d_resp) begin
        seen = 1;
        if (is_i) bus.i_read = 1'b0;
        else begin
          bus.d_read  = 1'b0;
          bus.d_write = 1'b0;
        end
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL resp_timeout actual=none required=%s", is_i ? "i_resp" : "d_resp");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, ib, db, done_n;
    bit d_first, re_i, re_d;
    bit order_d[$];

    vt[0] = '{1, 0, 32'h0000_0064,
              {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
              0, 32'h0000_0060, 4};
    vt[1] = '{0, 1, 32'h8000_0020,
              {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
               64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
              1, 32'h8000_0020, 8};
    vt[2] = '{0, 0, 32'h1234_567F,
              {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
               64'h0F0F_0F0F_F0F0_F0F0, 64'h5A5A_A5A5_5A5A_A5A5},
              1, 32'h1234_5660, 8};
    vt[3] = '{1, 0, 32'hFFFF_FFFF,
              {64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE,
               64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_0000_0000},
              0, 32'hFFFF_FFE0, 4};
    vt[4] = '{0, 1, 32'h0000_001F,
              {64'h1357_9BDF_2468_ACE0, 64'h0000_0000_0000_0000,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hC0DE_C0DE_C0DE_C0DE},
              0, 32'h0000_0000, 4};

    reset_n     = 1'b0;
    bus.i_read  = 1'b0;
    bus.i_addr  = '0;
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    #1;
    chk("rst_mem_read",  {255'd0, bus.mem_read}, 256'd0);
    chk("rst_mem_write", {255'd0, bus.mem_write}, 256'd0);
    chk("rst_i_resp",    {255'd0, bus.i_resp}, 256'd0);
    chk("rst_d_resp",    {255'd0, bus.d_resp}, 256'd0);
    chk("rst_mem_addr",  {224'd0, bus.mem_addr}, 256'd0);
    chk("rst_mem_wdata", {192'd0, bus.mem_wdata}, 256'd0);
    chk("rst_i_rdata",   bus.i_rdata, 256'd0);
    chk("rst_d_rdata",   bus.d_rdata, 256'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Table-driven single transactions. The request address and wdata are
    // scrambled after the grant to confirm that they were latched.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      mem_line   = vt[k].line;
      stall_mode = vt[k].stall;
      ib = i_resp_n;
      db = d_resp_n;
      sb.push_back('{vt[k].is_i, vt[k].is_wr, vt[k].exp_addr, vt[k].line});
      if (vt[k].is_i) begin
        bus.i_addr = vt[k].addr;
        bus.i_read = 1'b1;
      end else begin
        bus.d_addr  = vt[k].addr;
        bus.d_wdata = vt[k].line;
        bus.d_write = vt[k].is_wr;
        bus.d_read  = !vt[k].is_wr;
      end
      wait_resp(vt[k].is_i, 60, 1'b1);
      repeat (2) @(negedge clk);
      chk($sformatf("vec%0d_burst_cycles", k), 256'(last_cyc), 256'(vt[k].exp_cyc));
      chk($sformatf("vec%0d_resp_pulses", k), 256'((i_resp_n - ib) + (d_resp_n - db)), 256'd1);
      last_d = !vt[k].is_i;
    end
    stall_mode = 0;

    // Read lines stay put across later bursts of other kinds.
    chk("d_rdata_held", bus.d_rdata, vt[2].line);
    chk("i_rdata_held", bus.i_rdata, vt[3].line);

    // mem_resp while idle must not start or advance anything.
    b0 = bursts;
    ib = i_resp_n;
    db = d_resp_n;
    force_resp = 1;
    repeat (3) @(negedge clk);
    force_resp = 0;
    chk("idle_resp_no_strobe", {255'd0, bus.mem_read | bus.mem_write}, 256'd0);
    chk("idle_resp_no_burst", 256'(bursts - b0), 256'd0);
    chk("idle_resp_no_resp", 256'((i_resp_n - ib) + (d_resp_n - db)), 256'd0);
    @(negedge clk);

    // Simultaneous icache and dcache reads.
`ifdef ARB_ROUND_ROBIN_EN
    d_first = !last_d;
`else
    d_first = 1;
`endif
    mem_line = vt[2].line;
    if (d_first) begin
      sb.push_back('{0, 0, 32'h0000_4000, vt[2].line});
      sb.push_back('{1, 0, 32'h0000_5000, vt[2].line});
    end else begin
      sb.push_back('{1, 0, 32'h0000_5000, vt[2].line});
      sb.push_back('{0, 0, 32'h0000_4000, vt[2].line});
    end
    b0 = bursts;
    bus.d_addr = 32'h0000_4010;
    bus.i_addr = 32'h0000_5008;
    bus.d_read = 1'b1;
    bus.i_read = 1'b1;
    done_n = 0;
    for (int c = 0; c < 100 && done_n < 2; c++) begin
      @(negedge clk);
      if (bus.i_resp) begin bus.i_read = 1'b0; done_n++; end
      if (bus.d_resp) begin bus.d_read = 1'b0; done_n++; end
    end
    chk("simul_done", 256'(done_n), 256'd2);
    repeat (2) @(negedge clk);
    chk("simul_bursts", 256'(bursts - b0), 256'd2);
    chk("simul_gap", 256'(last_gap), 256'd2);
    last_d = !d_first;

    // d_read and d_write together: the write must win.
    @(negedge clk);
    db = d_resp_n;
    sb.push_back('{0, 1, 32'h0000_7700, vt[1].line});
    bus.d_addr  = 32'h0000_7711;
    bus.d_wdata = vt[1].line;
    bus.d_read  = 1'b1;
    bus.d_write = 1'b1;
    wait_resp(0, 60, 1'b0);
    repeat (2) @(negedge clk);
    chk("illegal_d_resp_once", 256'(d_resp_n - db), 256'd1);
    last_d = 1;

    // Reset asserted after the second accepted beat of an icache read.
    mem_line = vt[0].line;
    ib = i_resp_n;
    bus.i_addr = 32'h0000_1040;
    bus.i_read = 1'b1;
    done_n = 0;
    for (int c = 0; c < 40 && done_n < 2; c++) begin
      @(posedge clk);
      if (bus.mem_resp && bus.mem_read) done_n++;
    end
    chk("rst_mid_beats_seen", 256'(done_n), 256'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_mem_read", {255'd0, bus.mem_read}, 256'd0);
    chk("rst_mid_i_resp", {255'd0, bus.i_resp}, 256'd0);
    repeat (2) @(negedge clk);
    chk("rst_mid_no_i_resp", 256'(i_resp_n - ib), 256'd0);
    sb.push_back('{1, 0, 32'h0000_1040, vt[0].line});
    reset_n = 1'b1;
    wait_resp(1, 60, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_fresh_cycles", 256'(last_cyc), 256'd4);
    last_d = 0;

`ifdef ARB_ROUND_ROBIN_EN
    // Both caches keep requesting. Grants must alternate.
    @(negedge clk);
    mem_line = vt[3].line;
    order_d.delete();
    for (int n = 0; n < 4; n++) order_d.push_back((n % 2 == 0) ? !last_d : last_d);
    for (int n = 0; n < 4; n++) begin
      if (order_d[n]) sb.push_back('{0, 0, 32'h0000_3000, vt[3].line});
      else            sb.push_back('{1, 0, 32'h0000_2000, vt[3].line});
    end
    bus.i_addr = 32'h0000_2000;
    bus.d_addr = 32'h0000_3000;
    bus.i_read = 1'b1;
    bus.d_read = 1'b1;
    done_n = 0;
    re_i = 0;
    re_d = 0;
    for (int c = 0; c < 200 && done_n < 4; c++) begin
      @(negedge clk);
      if (re_i) begin bus.i_read = 1'b1; re_i = 0; end
      if (re_d) begin bus.d_read = 1'b1; re_d = 0; end
      if (bus.i_resp) begin bus.i_read = 1'b0; re_i = 1; done_n++; end
      if (bus.d_resp) begin bus.d_read = 1'b0; re_d = 1; done_n++; end
    end
    bus.i_read = 1'b0;
    bus.d_read = 1'b0;
    chk("rr_done", 256'(done_n), 256'd4);
    repeat (3) @(negedge clk);
`endif

    chk("sb_drained", 256'(sb.size()), 256'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cacheline_mem_arbiter.md
Name: cacheline_mem_arbiter

Overview:
- Sits directly downstream of the instruction and data caches, between them and the mp4 burst memory port (mem_read/mem_write/mem_addr/mem_wdata/mem_rdata/mem_resp).
- Arbitrates line-fill and writeback requests from both caches onto the single physical memory port.
- Converts each 256-bit cacheline into a fixed 4-beat, 64-bit burst and back.
- Its memory-side ports drive the top-level memory ports of mp4.

Parameters:
- BURST_LEN, 4, beats per line transfer.
- BEAT_W, 64, memory data width per beat.
- LINE_W, 256, cacheline width; must equal BURST_LEN*BEAT_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_read  in  1  icache line-fill request.
- i_addr  in  32  icache line address.
- i_rdata  out  LINE_W  line returned to icache.
- i_resp  out  1  icache completion pulse.
- d_read  in  1  dcache line-fill request.
- d_write  in  1  dcache writeback request.
- d_addr  in  32  dcache line address.
- d_wdata  in  LINE_W  writeback line.
- d_rdata  out  LINE_W  line returned to dcache.
- d_resp  out  1  dcache completion pulse.
- mem_read  out  1  burst read request.
- mem_write  out  1  burst write request.
- mem_addr  out  32  burst base address.
- mem_wdata  out  BEAT_W  current write beat.
- mem_rdata  in  BEAT_W  current read beat.
- mem_resp  in  1  beat accepted/valid.

Behaviour:
- States: IDLE, I_RD, D_RD, D_WR, DONE. A 2-bit beat counter tracks position within the burst.
- Reset (async, reset_n low):
  - State goes to IDLE and the beat counter to 0.
  - mem_read, mem_write, i_resp and d_resp are driven 0 immediately, not at the next edge.
  - i_rdata, d_rdata, mem_addr and mem_wdata are 0.
- IDLE grant, default priority: d_write > d_read > i_read.
  - d_read and d_write both high is illegal; write wins.
  - On grant, latch mem_addr = {addr[31:5],5'b0} and, for writes, the full d_wdata line; clear the beat counter.
  - Grant takes effect at the next edge. mem_read/mem_write go high in the first cycle of I_RD/D_RD/D_WR.
- Burst phase:
  - mem_read or mem_write is held high continuously until the cycle in which the BURST_LEN-th mem_resp is sampled.
  - On each sampled mem_resp, the beat counter increments.
  - Reads capture mem_rdata into line bits [BEAT_W*k +: BEAT_W] of the granted client's rdata register (beat 0 = LSBs).
  - Writes present mem_wdata = latched line beat k, advancing on mem_resp.
  - mem_resp low means stall: no state change.
- Last beat: state goes to DONE.
  - mem_read/mem_write are 0 in DONE.
  - The granted client's resp is 1 for exactly the DONE cycle; its rdata is valid in DONE and held until that client's next read completes.
  - DONE always returns to IDLE; no grant is issued in DONE. The client drops its request in the DONE cycle, so it is not re-granted.
- A request withdrawn mid-burst does not abort: the burst runs to completion and resp still pulses.
- Client address/wdata changes after grant are ignored (latched).
- mem_resp while in IDLE or DONE is ignored.
- Minimum turnaround between consecutive bursts: 2 cycles of memory-port idle (DONE, IDLE).
- The non-granted client's resp stays 0; its request stays pending and is granted from the next IDLE.

Optional Feature:
- ARB_ROUND_ROBIN_EN
- Defined: a 1-bit last_grant register (reset 0 = icache) is updated at each grant.
  - When both caches request in IDLE, the client not granted last wins.
  - Within the dcache, write still beats read.
- Undefined: fixed priority d_write > d_read > i_read, no last_grant register.

Test Plan:
- Icache fill alone:
  - Stimulus: i_read=1, i_addr=0x0000_0064; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with mem_resp every cycle.
  - Response: mem_addr=0x0000_0060, mem_read high for 4 cycles, i_resp one-cycle pulse, i_rdata=0x44..44_33..33_22..22_11..11.
- Dcache writeback with stalls:
  - Stimulus: d_write=1, d_addr=0x8000_0020, d_wdata beats A,B,C,D; mem_resp arrives every other cycle.
  - Response: mem_wdata shows A,B,C,D in order, each held until its mem_resp; mem_write high through 8 cycles; d_resp pulse once.
- Simultaneous requests:
  - Stimulus: i_read and d_read asserted on the same cycle.
  - Response: dcache served first; icache granted in the IDLE after dcache's DONE; exactly two bursts, with mem idle for 2 cycles between them.
- Round-robin (ARB_ROUND_ROBIN_EN defined):
  - Stimulus: both caches request continuously for 4 transactions.
  - Response: grant order D, I, D, I.
- Reset mid-burst:
  - Stimulus: reset_n pulled low after the 2nd mem_resp of an icache read.
  - Response: mem_read=0 in the same cycle; no i_resp; after release, a fresh request completes a full 4-beat burst from beat 0.
- Illegal d_read+d_write:
  - Stimulus: both asserted together.
  - Response: a write burst executes; d_resp pulses once.
